pcie_c2h_dsc_sched: RTL and testbench
=====================================

PCIE_C2H_DSC_SCHED -- requirements
Module: pcie_c2h_dsc_sched

Interface
REQ-001 SHALL have parameter RING_BASE, default 64'h1_0000_0000: host physical base of the C2H receive ring, reserved via memmap.
REQ-002 SHALL have parameter NUM_SLOTS, default 16: ring slot count, power of two, 2..256.
REQ-003 SHALL have parameter SLOT_LEN, default 28'h1000: bytes per slot and per descriptor.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 4: maximum descriptors accepted by XDMA but not yet completed, 1..15.
REQ-005 user_clk_250  in  1  sole clock; XDMA axi_aclk.
REQ-006 user_resetn_250  in  1  asynchronous, active-low reset; XDMA axi_aresetn.
REQ-007 enable  in  1  scheduling permitted (driven from user_lnk_up).
REQ-008 credit_ret  in  1  one-cycle pulse: host has consumed one slot.
REQ-009 dsc_byp_ready  in  1  XDMA C2H bypass ready.
REQ-010 dsc_byp_load  out  1  descriptor valid.
REQ-011 dsc_byp_dst_addr  out  64  slot host address.
REQ-012 dsc_byp_src_addr  out  64  constant 0.
REQ-013 dsc_byp_len  out  28  constant SLOT_LEN.
REQ-014 dsc_byp_ctl  out  16  constant 16'h0.
REQ-015 c2h_tvalid, c2h_tready, c2h_tlast  in  1 each  monitor taps of the S_AXIS_C2H handshake.
REQ-016 free_slots  out  9  host-free slot count.
REQ-017 inflight  out  4  outstanding descriptors.
REQ-018 err_sticky  out  2  bit0 credit overflow, bit1 tlast underflow.
REQ-019 stat_dsc, stat_pkt  out  32 each  statistics (see Configuration).

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, and WAIT.
- IDLE->ISSUE when enable, free_slots>0, and inflight<MAX_INFLIGHT.
- ISSUE->WAIT on accept.
- WAIT->IDLE next cycle.
REQ-021 dsc_byp_load SHALL be registered, high exactly in ISSUE, with all descriptor fields stable while high.
REQ-022 Accept SHALL be the cycle where dsc_byp_load && dsc_byp_ready; load SHALL deassert the cycle after accept.
REQ-023 dst_addr SHALL equal RING_BASE + slot_idx*SLOT_LEN, computed at 64 bits.
REQ-024 slot_idx SHALL increment on accept and wrap from NUM_SLOTS-1 to 0.
REQ-025 free_slots SHALL update as follows:
- -1 on accept.
- +1 on credit_ret.
- Unchanged when both occur in the same cycle.
- credit_ret with free_slots==NUM_SLOTS and no accept: ignored, sets err_sticky[0].
REQ-026 inflight SHALL update as follows:
- +1 on accept.
- -1 on completion (c2h_tvalid && c2h_tready && c2h_tlast).
- Unchanged when both occur in the same cycle.
- Completion with inflight==0 and no accept: ignored, sets err_sticky[1].
REQ-027 enable deasserting in ISSUE SHALL NOT withdraw load; the FSM returns to IDLE only after accept.
REQ-028 Minimum spacing between accepts SHALL be 3 cycles; no combinational path from inputs to outputs.

Reset
REQ-029 On user_resetn_250 low, asynchronously:
- FSM=IDLE, load=0, slot_idx=0, dst_addr=RING_BASE.
- free_slots=NUM_SLOTS, inflight=0, err_sticky=0, stat_*=0.
REQ-030 Reset asserted mid-ISSUE SHALL drop load immediately; after deassertion, issue SHALL restart at slot 0.

Configuration
REQ-031 Macro C2H_SCHED_STATS_EN defined: stat_dsc counts accepts and stat_pkt counts completions; both are 32-bit and wrap at 2^32.
REQ-032 Macro undefined: stat_dsc and stat_pkt SHALL be tied to 0 with no counter logic.

Verification
REQ-033 Defaults, enable=1, ready=1, no tlast: exactly 4 descriptors, dst 0x1_0000_0000/1000/2000/3000, then load stays 0 and inflight=4.
REQ-034 Ready held low 10 cycles in ISSUE: load held high with dst constant for all 10 cycles; accepted on the first ready cycle.
REQ-035 Issue 16 descriptors with immediate completions and no credits: free_slots reaches 0 and issue stops; 1 credit_ret produces the next dst 0x1_0000_0000 (wrap).
REQ-036 credit_ret coincident with accept at free_slots=5: free_slots stays 5; credit_ret at free_slots=16 sets err_sticky=2'b01.
REQ-037 tlast handshake with inflight=0 sets err_sticky=2'b10; reset asserted while load=1 forces load=0 and next dst=RING_BASE.
REQ-038 With C2H_SCHED_STATS_EN defined, 7 accepts and 5 completions give stat_dsc=7 and stat_pkt=5; undefined, both read 0.

Source files
------------

// File: rtl/pcie_c2h_dsc_sched.sv
// C2H descriptor bypass scheduler: walks a host receive ring, gated by host slot credits and XDMA in-flight limit.
// Optional statistics counters are built when C2H_SCHED_STATS_EN is defined.
module pcie_c2h_dsc_sched #(
   parameter logic [63:0] RING_BASE    = 64'h1_0000_0000,
   parameter int          NUM_SLOTS    = 16,
   parameter logic [27:0] SLOT_LEN     = 28'h1000,
   parameter int          MAX_INFLIGHT = 4
) (
   input  logic        user_clk_250,
   input  logic        user_resetn_250,
   input  logic        enable,
   input  logic        credit_ret,
   input  logic        dsc_byp_ready,
   output logic        dsc_byp_load,
   output logic [63:0] dsc_byp_dst_addr,
   output logic [63:0] dsc_byp_src_addr,
   output logic [27:0] dsc_byp_len,
   output logic [15:0] dsc_byp_ctl,
   input  logic        c2h_tvalid,
   input  logic        c2h_tready,
   input  logic        c2h_tlast,
   output logic [8:0]  free_slots,
   output logic [3:0]  inflight,
   output logic [1:0]  err_sticky,
   output logic [31:0] stat_dsc,
   output logic [31:0] stat_pkt
);

   localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t        state, state_nxt;
   logic [SW-1:0] slot_idx, slot_nxt;
   logic          accept, cmpl;

   assign accept   = dsc_byp_load && dsc_byp_ready;
   assign cmpl     = c2h_tvalid && c2h_tready && c2h_tlast;
   assign slot_nxt = slot_idx + SW'(1);

   assign dsc_byp_src_addr = 64'h0;
   assign dsc_byp_len      = SLOT_LEN;
   assign dsc_byp_ctl      = 16'h0;

   // WAIT costs one cycle so counters settle before the next eligibility test.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable && free_slots != 9'd0 && inflight < 4'(MAX_INFLIGHT))
                     state_nxt = ISSUE;
         ISSUE:   if (accept) state_nxt = WAIT;
         WAIT:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge user_clk_250 or negedge user_resetn_250) begin
      if (!user_resetn_250) begin
         state            <= IDLE;
         dsc_byp_load     <= 1'b0;
         slot_idx         <= '0;
         dsc_byp_dst_addr <= RING_BASE;
      end else begin
         state        <= state_nxt;
         dsc_byp_load <= (state_nxt == ISSUE);
         if (accept) begin
            slot_idx         <= slot_nxt;
            dsc_byp_dst_addr <= RING_BASE + 64'(slot_nxt) * 64'(SLOT_LEN);
         end
      end
   end

   // Simultaneous increment and decrement cancel; out-of-range events only flag an error.
   always_ff @(posedge user_clk_250 or negedge user_resetn_250) begin
      if (!user_resetn_250) begin
         free_slots <= 9'(NUM_SLOTS);
         inflight   <= 4'd0;
         err_sticky <= 2'b00;
      end else begin
         case ({accept, credit_ret})
            2'b10:   free_slots <= free_slots - 9'd1;
            2'b01:   if (free_slots == 9'(NUM_SLOTS)) err_sticky[0] <= 1'b1;
                     else free_slots <= free_slots + 9'd1;
            default: ;
         endcase
         case ({accept, cmpl})
            2'b10:   inflight <= inflight + 4'd1;
            2'b01:   if (inflight == 4'd0) err_sticky[1] <= 1'b1;
                     else inflight <= inflight - 4'd1;
            default: ;
         endcase
      end
   end

`ifdef C2H_SCHED_STATS_EN
   always_ff @(posedge user_clk_250 or negedge user_resetn_250) begin
      if (!user_resetn_250) begin
         stat_dsc <= 32'd0;
         stat_pkt <= 32'd0;
      end else begin
         stat_dsc <= stat_dsc + 32'(accept);
         stat_pkt <= stat_pkt + 32'(cmpl);
      end
   end
`else
   assign stat_dsc = 32'd0;
   assign stat_pkt = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_c2h_dsc_sched.sv
// Bench for pcie_c2h_dsc_sched: directed scenarios plus random traffic against a ring/credit reference model.
module tb_pcie_c2h_dsc_sched;

   localparam logic [63:0] RING_BASE    = 64'h1_0000_0000;
   localparam int          NUM_SLOTS    = 16;
   localparam logic [27:0] SLOT_LEN     = 28'h1000;
   localparam int          MAX_INFLIGHT = 4;

   logic clk = 1'b0, rst_n = 1'b0;
   logic en = 0, rdy = 0, cr = 0, tv = 0, tr = 0, tl = 0;
   logic        dsc_byp_load;
   logic [63:0] dsc_byp_dst_addr, dsc_byp_src_addr;
   logic [27:0] dsc_byp_len;
   logic [15:0] dsc_byp_ctl;
   logic [8:0]  free_slots;
   logic [3:0]  inflight;
   logic [1:0]  err_sticky;
   logic [31:0] stat_dsc, stat_pkt;

   always #5 clk = ~clk;

   pcie_c2h_dsc_sched #(.RING_BASE(RING_BASE), .NUM_SLOTS(NUM_SLOTS), .SLOT_LEN(SLOT_LEN),
                        .MAX_INFLIGHT(MAX_INFLIGHT)) dut (
      .user_clk_250(clk), .user_resetn_250(rst_n), .enable(en), .credit_ret(cr),
      .dsc_byp_ready(rdy), .dsc_byp_load(dsc_byp_load), .dsc_byp_dst_addr(dsc_byp_dst_addr),
      .dsc_byp_src_addr(dsc_byp_src_addr), .dsc_byp_len(dsc_byp_len), .dsc_byp_ctl(dsc_byp_ctl),
      .c2h_tvalid(tv), .c2h_tready(tr), .c2h_tlast(tl), .free_slots(free_slots),
      .inflight(inflight), .err_sticky(err_sticky), .stat_dsc(stat_dsc), .stat_pkt(stat_pkt));

   int checks = 0, errors = 0;

   // Reference model: ring position, credit pool, outstanding count, sticky errors, event totals.
   int          m_free, m_infl, m_slot, idle_cnt;
   logic [1:0]  m_err;
   logic [31:0] m_dsc, m_pkt;
   bit          p_acc;
   logic [63:0] acc_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_free = NUM_SLOTS; m_infl = 0; m_slot = 0; m_err = 2'b00;
      m_dsc = 0; m_pkt = 0; p_acc = 0; idle_cnt = 0;
   endtask

   task automatic chk_state();
      logic [31:0] e_dsc, e_pkt;
`ifdef C2H_SCHED_STATS_EN
      e_dsc = m_dsc; e_pkt = m_pkt;
`else
      e_dsc = 0; e_pkt = 0;
`endif
      chk("dst", dsc_byp_dst_addr, RING_BASE + 64'(m_slot) * 64'(SLOT_LEN));
      chk("free_slots", 64'(free_slots), 64'(m_free));
      chk("inflight", 64'(inflight), 64'(m_infl));
      chk("err_sticky", 64'(err_sticky), 64'(m_err));
      chk("stat_dsc", 64'(stat_dsc), 64'(e_dsc));
      chk("stat_pkt", 64'(stat_pkt), 64'(e_pkt));
   endtask

   // One clock: drive at negedge, advance model, check behaviour at the following negedge.
   task automatic cyc(input bit e, input bit r, input bit c, input bit v, input bit t, input bit l);
      bit acc, cmp, elig, ld0;
      logic [63:0] dst0;
      en = e; rdy = r; cr = c; tv = v; tr = t; tl = l;
      ld0 = dsc_byp_load; dst0 = dsc_byp_dst_addr;
      acc  = ld0 && r;
      cmp  = v && t && l;
      elig = e && m_free > 0 && m_infl < MAX_INFLIGHT;
      if (!ld0 && elig) idle_cnt++; else idle_cnt = 0;
      chk("issue_latency", 64'(idle_cnt <= 2), 64'd1);
      if (acc && !c) m_free--;
      else if (!acc && c) begin
         if (m_free == NUM_SLOTS) m_err[0] = 1'b1; else m_free++;
      end
      if (acc && !cmp) m_infl++;
      else if (!acc && cmp) begin
         if (m_infl == 0) m_err[1] = 1'b1; else m_infl--;
      end
      if (acc) begin
         m_slot = (m_slot + 1) % NUM_SLOTS;
         m_dsc++;
         acc_q.push_back(dst0);
      end
      if (cmp) m_pkt++;
      @(negedge clk);
      if (ld0 && !acc) begin
         chk("load_hold", 64'(dsc_byp_load), 64'd1);
         chk("dst_hold", dsc_byp_dst_addr, dst0);
      end
      if (acc || p_acc) chk("load_gap", 64'(dsc_byp_load), 64'd0);
      if (dsc_byp_load && !ld0) chk("load_rise_elig", 64'(elig), 64'd1);
      p_acc = acc;
      chk_state();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 0; rdy = 0; cr = 0; tv = 0; tr = 0; tl = 0;
      repeat (2) @(negedge clk);
      model_reset();
      chk("rst_load", 64'(dsc_byp_load), 64'd0);
      chk("rst_src", dsc_byp_src_addr, 64'd0);
      chk("rst_len", 64'(dsc_byp_len), 64'h1000);
      chk("rst_ctl", 64'(dsc_byp_ctl), 64'd0);
      chk_state();
      rst_n = 1'b1;
   endtask

   task automatic wait_load(input string tag);
      int n = 0;
      while (!dsc_byp_load && n < 10) begin cyc(1, 0, 0, 0, 0, 0); n++; end
      chk(tag, 64'(dsc_byp_load), 64'd1);
   endtask

   // Issue n descriptors, completing outstanding ones each cycle up to max_cmp completions.
   task automatic issue_n(input int n, input int max_cmp, input string tag);
      int k = 0, done = 0;
      bit c;
      acc_q.delete();
      while (acc_q.size() < n && k < 300) begin
         c = (m_infl > 0) && (done < max_cmp);
         if (c) done++;
         cyc(1, 1, 0, c, c, c);
         k++;
      end
      chk(tag, 64'(acc_q.size()), 64'(n));
   endtask

   task automatic wait_accept(input string tag);
      int n = 0;
      while (acc_q.size() == 0 && n < 10) begin cyc(1, 1, 0, 0, 0, 0); n++; end
      chk(tag, 64'(acc_q.size()), 64'd1);
   endtask

   initial begin
      logic [63:0] d;
      logic [63:0] t1_exp[4] = '{64'h1_0000_0000, 64'h1_0000_1000, 64'h1_0000_2000, 64'h1_0000_3000};

      // Free-running issue stops at the in-flight limit.
      do_reset();
      acc_q.delete();
      repeat (20) cyc(1, 1, 0, 0, 0, 0);
      chk("t1_count", 64'(acc_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < acc_q.size(); i++) chk("t1_dst", acc_q[i], t1_exp[i]);
      chk("t1_load", 64'(dsc_byp_load), 64'd0);
      chk("t1_inflight", 64'(inflight), 64'd4);

      // Backpressure holds the descriptor, even with enable dropped.
      do_reset();
      wait_load("t2_load_up");
      d = dsc_byp_dst_addr;
      for (int i = 0; i < 10; i++) begin
         cyc(i < 5, 0, 0, 0, 0, 0);
         chk("t2_load", 64'(dsc_byp_load), 64'd1);
         chk("t2_dst", dsc_byp_dst_addr, d);
      end
      acc_q.delete();
      cyc(0, 1, 0, 0, 0, 0);
      chk("t2_acc", 64'(acc_q.size()), 64'd1);
      chk("t2_acc_dst", acc_q[0], 64'h1_0000_0000);

      // Ring exhaustion and wrap after a credit.
      do_reset();
      issue_n(16, 1000, "t3_issue16");
      repeat (10) cyc(1, 1, 0, 0, 0, 0);
      chk("t3_free0", 64'(free_slots), 64'd0);
      chk("t3_noload", 64'(dsc_byp_load), 64'd0);
      acc_q.delete();
      cyc(1, 1, 1, 0, 0, 0);
      wait_accept("t3_wrap_acc");
      chk("t3_wrap_dst", acc_q[0], 64'h1_0000_0000);

      // Credit coincident with accept, then credit overflow.
      do_reset();
      issue_n(11, 1000, "t4_issue11");
      wait_load("t4_load_up");
      chk("t4_free5", 64'(free_slots), 64'd5);
      cyc(1, 1, 1, 0, 0, 0);
      chk("t4_free_coinc", 64'(free_slots), 64'd5);
      repeat (11) cyc(0, 0, 1, 0, 0, 0);
      chk("t4_free16", 64'(free_slots), 64'd16);
      chk("t4_err_none", 64'(err_sticky), 64'd0);
      cyc(0, 0, 1, 0, 0, 0);
      chk("t4_err_ovf", 64'(err_sticky), 64'b01);

      // Completion underflow, then reset in the middle of an issue.
      do_reset();
      cyc(0, 0, 0, 1, 1, 1);
      chk("t5_err_udf", 64'(err_sticky), 64'b10);
      wait_load("t5_load_up");
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_load", 64'(dsc_byp_load), 64'd0);
      chk("t5_rst_dst", dsc_byp_dst_addr, RING_BASE);
      model_reset();
      @(negedge clk);
      chk_state();
      rst_n = 1'b1;
      acc_q.delete();
      wait_accept("t5_acc");
      chk("t5_acc_dst", acc_q[0], RING_BASE);

      // Statistics: 7 accepts, 5 completions.
      do_reset();
      issue_n(7, 5, "t6_issue7");
      repeat (3) cyc(0, 0, 0, 0, 0, 0);
`ifdef C2H_SCHED_STATS_EN
      chk("t6_stat_dsc", 64'(stat_dsc), 64'd7);
      chk("t6_stat_pkt", 64'(stat_pkt), 64'd5);
`else
      chk("t6_stat_dsc", 64'(stat_dsc), 64'd0);
      chk("t6_stat_pkt", 64'(stat_pkt), 64'd0);
`endif

      // Random traffic against the model.
      do_reset();
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
